// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous ROM address and loads the
// fetch/decode register, handling decode stalls, branch redirects and halt/resume.
module fetch_controller #(
   parameter int                 ADDR_W   = 16,
   parameter int                 INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   input  logic               i_halt_req,
   input  logic               i_resume,
   output logic [ADDR_W-1:0]  o_rom_addr,
   input  logic [INSTR_W-1:0] i_rom_q,
   output logic [INSTR_W-1:0] o_fd_instr,
   output logic [ADDR_W-1:0]  o_fd_pc,
   output logic               o_fd_valid,
   output logic [15:0]        o_fetch_cnt,
   output logic [1:0]         o_state
);

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    r_req_pc;
   logic                 r_req_valid;
   logic [INSTR_W-1:0]   r_fd_instr;
   logic [ADDR_W-1:0]    r_fd_pc;
   logic                 r_fd_valid;
   logic [15:0]          r_fetch_cnt;
   logic [ADDR_W-1:0]    w_rom_addr;
   logic [ADDR_W-1:0]    w_pc_inc;
   logic [ADDR_W-1:0]    w_redir_inc;

   assign w_pc_inc    = r_pc + ADDR_W'(1);
   assign w_redir_inc = i_redirect_pc + ADDR_W'(1);

   // While the in-flight word is held under stall, re-issue its address so rom_q stays stable.
   always_comb begin
      w_rom_addr = r_pc;
      if (i_redirect)
         w_rom_addr = i_redirect_pc;
      else if ((r_state == S_RUN || r_state == S_DRAIN) && i_stall)
         w_rom_addr = r_req_pc;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_BOOT;
         r_pc        <= RESET_PC;
         r_req_pc    <= '0;
         r_req_valid <= 1'b0;
         r_fd_instr  <= '0;
         r_fd_pc     <= '0;
         r_fd_valid  <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         case (r_state)
            S_BOOT, S_RUN, S_DRAIN: begin
               if (i_redirect) begin
                  r_fd_valid  <= 1'b0;
                  r_req_pc    <= i_redirect_pc;
                  r_req_valid <= 1'b1;
                  r_pc        <= w_redir_inc;
                  r_state     <= S_RUN;
               end else if (r_state == S_BOOT) begin
                  r_req_pc    <= r_pc;
                  r_req_valid <= 1'b1;
                  r_pc        <= w_pc_inc;
                  r_state     <= S_RUN;
               end else if (!i_stall) begin
                  r_fd_instr <= i_rom_q;
                  r_fd_pc    <= r_req_pc;
                  r_fd_valid <= r_req_valid;
                  if (r_req_valid) r_fetch_cnt <= r_fetch_cnt + 16'd1;
                  if (r_state == S_RUN && !i_halt_req) begin
                     r_req_pc    <= r_pc;
                     r_req_valid <= 1'b1;
                     r_pc        <= w_pc_inc;
                  end else begin
                     r_req_valid <= 1'b0;
                     r_state     <= (r_state == S_RUN) ? S_DRAIN : S_HALTED;
                  end
               end else if (r_state == S_RUN && i_halt_req) begin
                  // Stalled halt: keep the in-flight word and let DRAIN deliver it.
                  r_state <= S_DRAIN;
               end
            end
            default: begin
               if (!i_stall) r_fd_valid <= 1'b0;
               if (i_redirect) begin
                  r_pc <= i_redirect_pc;
               end else if (i_resume && !i_halt_req) begin
                  r_req_pc    <= r_pc;
                  r_req_valid <= 1'b1;
                  r_pc        <= w_pc_inc;
                  r_state     <= S_RUN;
               end
            end
         endcase
      end
   end

   assign o_rom_addr  = w_rom_addr;
   assign o_fd_instr  = r_fd_instr;
   assign o_fd_pc     = r_fd_pc;
   assign o_fd_valid  = r_fd_valid;
   assign o_fetch_cnt = r_fetch_cnt;
   assign o_state     = r_state;

endmodule
